// File: rtl/dmem_arb_pkg.sv
// Shared state encoding, access-size codes and request bundle for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int ARB_ADDR_W = 9;
    localparam int ARB_DATA_W = 32;

    typedef enum logic {
        S_C = 1'b0,
        S_D = 1'b1
    } arb_state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
    } req_t;

endpackage

// File: rtl/dmem_resp_reg.sv
// Per-requester load response: captures memory read data on a load grant and
// pulses rvalid for the following cycle; rdata holds until the next load.
module dmem_resp_reg
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_gnt,
    input  logic [DATA_W-1:0] i_rd,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata
);

    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= i_load_gnt;
            if (i_load_gnt) begin
                r_rdata <= i_rd;
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (C = load/store stage, D = DMA) arbiter in front of a single-port data memory.
// Define DMEM_ARB_STATS_EN to add saturating per-requester stall counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int BURST_MAX    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [2:0]            c_funct3,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     c_rdata,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]           c_stall_cnt,
    output logic [15:0]           d_stall_cnt
`endif
);

    localparam logic [3:0] BURST_MAX_C    = 4'(BURST_MAX);
    localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);

    arb_state_t  r_state, w_state_next;
    logic [3:0]  r_burst_cnt, w_burst_next;
    logic [7:0]  r_starve_cnt, w_starve_next;
    logic        w_gnt_c, w_gnt_d, w_starved;
    req_t        w_c_req, w_d_req, w_sel_req;
    logic [1:0]  w_valid, w_gnt, w_load_gnt, w_rvalid;
    logic [DATA_W-1:0] w_rdata [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_C;
            r_burst_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_burst_cnt  <= w_burst_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    assign w_starved = d_valid && (r_starve_cnt == STARVE_LIMIT_C);

    always_comb begin
        w_gnt_c      = 1'b0;
        w_gnt_d      = 1'b0;
        w_state_next = r_state;
        w_burst_next = r_burst_cnt;
        if (r_state == S_C) begin
            if (c_valid && !w_starved) begin
                w_gnt_c = 1'b1;
            end else if (d_valid) begin
                w_gnt_d      = 1'b1;
                w_state_next = S_D;
                w_burst_next = 4'd1;
            end
        end else begin
            // An idle C lets D keep going past the burst cap.
            if (d_valid && ((r_burst_cnt < BURST_MAX_C) || !c_valid)) begin
                w_gnt_d = 1'b1;
                if (r_burst_cnt < BURST_MAX_C) begin
                    w_burst_next = r_burst_cnt + 4'd1;
                end
            end else begin
                w_gnt_c      = c_valid;
                w_state_next = S_C;
                w_burst_next = '0;
            end
        end
    end

    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_gnt_d) begin
            w_starve_next = '0;
        end else if (d_valid && (r_starve_cnt < STARVE_LIMIT_C)) begin
            w_starve_next = r_starve_cnt + 8'd1;
        end
    end

    assign w_c_req   = '{we: c_we, addr: c_addr, wdata: c_wdata, funct3: c_funct3};
    assign w_d_req   = '{we: d_we, addr: d_addr, wdata: d_wdata, funct3: d_funct3};
    assign w_sel_req = w_gnt_d ? w_d_req : w_c_req;

    assign c_ready  = rst_n & w_gnt_c;
    assign d_ready  = rst_n & w_gnt_d;
    assign MemRead  = rst_n & (w_gnt_c | w_gnt_d) & ~w_sel_req.we;
    assign MemWrite = rst_n & (w_gnt_c | w_gnt_d) &  w_sel_req.we;
    assign a        = w_sel_req.addr;
    assign wd       = w_sel_req.wdata;
    assign Funct3   = w_sel_req.funct3;

    // Index 0 is requester C, index 1 is requester D.
    assign w_valid    = {d_valid, c_valid};
    assign w_gnt      = {w_gnt_d, w_gnt_c};
    assign w_load_gnt = {w_gnt_d & ~d_we, w_gnt_c & ~c_we};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            dmem_resp_reg #(
                .DATA_W (DATA_W)
            ) u_resp (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_load_gnt (w_load_gnt[gi]),
                .i_rd       (rd),
                .o_rvalid   (w_rvalid[gi]),
                .o_rdata    (w_rdata[gi])
            );
        end
    endgenerate

    assign c_rvalid = w_rvalid[0];
    assign c_rdata  = w_rdata[0];
    assign d_rvalid = w_rvalid[1];
    assign d_rdata  = w_rdata[1];

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_stall_cnt [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stall
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stall_cnt[gi] <= '0;
                end else if (w_valid[gi] && !w_gnt[gi] && (r_stall_cnt[gi] != 16'hFFFF)) begin
                    r_stall_cnt[gi] <= r_stall_cnt[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign c_stall_cnt = r_stall_cnt[0];
    assign d_stall_cnt = r_stall_cnt[1];
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{w_valid, w_gnt};
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed request streams, a behavioural arbitration/memory
// model checked every cycle, and literal expectations for each scenario.
module tb_dmem_arbiter;

    localparam int AW           = 9;
    localparam int DW           = 32;
    localparam int BURST_MAX    = 4;
    localparam int STARVE_LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_valid, c_ready, c_we, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic [2:0]    c_funct3;
    logic          d_valid, d_ready, d_we, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [2:0]    d_funct3;
    logic          MemRead, MemWrite;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [2:0]    Funct3;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   c_stall_cnt, d_stall_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DM_ADDRESS   (AW),
        .DATA_W       (DW),
        .BURST_MAX    (BURST_MAX),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_funct3 (c_funct3),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_funct3 (d_funct3),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .a        (a),
        .wd       (wd),
        .Funct3   (Funct3),
        .rd       (rd)
`ifdef DMEM_ARB_STATS_EN
        ,
        .c_stall_cnt (c_stall_cnt),
        .d_stall_cnt (d_stall_cnt)
`endif
    );

    // Physical memory driven by the DUT, and the model's own view of memory.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] mm  [0:(1<<AW)-1];
    assign rd = mem[a];

    initial forever begin
        @(posedge clk);
        if (MemWrite) mem[a] <= wd;
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    f3;
    } treq_t;

    treq_t c_buf [64];
    treq_t d_buf [64];
    int    c_tail = 0, d_tail = 0;
    int    c_pop = 0, d_pop = 0;
    int    c_acc = 0, d_acc = 0;

    int    n_cmp = 0;
    int    n_bad = 0;

    // Model state
    bit            m_d_owns = 1'b0;
    int            m_burst = 0;
    int            m_starve = 0;
    logic          m_c_rv = 1'b0, m_d_rv = 1'b0;
    logic [DW-1:0] m_c_rdata = '0, m_d_rdata = '0;
    int            m_c_stall = 0, m_d_stall = 0;

    string         glog = "";
    int            c_rv_cnt = 0, d_rv_cnt = 0;
    logic [DW-1:0] c_last = '0, d_last = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got '%s' expected '%s' at %0t", nm, act, exp, $time);
        end
    endtask

    // Request drivers: present the oldest unaccepted request, hold it until accepted.
    initial begin
        c_valid = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_funct3 = '0;
        forever begin
            @(posedge clk); #1;
            c_pop = c_acc;
            if (c_pop < c_tail) begin
                c_valid  = 1'b1;
                c_we     = c_buf[c_pop].we;
                c_addr   = c_buf[c_pop].addr;
                c_wdata  = c_buf[c_pop].wdata;
                c_funct3 = c_buf[c_pop].f3;
            end else begin
                c_valid = 1'b0;
            end
        end
    end

    initial begin
        d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
        forever begin
            @(posedge clk); #1;
            d_pop = d_acc;
            if (d_pop < d_tail) begin
                d_valid  = 1'b1;
                d_we     = d_buf[d_pop].we;
                d_addr   = d_buf[d_pop].addr;
                d_wdata  = d_buf[d_pop].wdata;
                d_funct3 = d_buf[d_pop].f3;
            end else begin
                d_valid = 1'b0;
            end
        end
    end

    // Compare process: decide the winner from the arbitration rules, check every output.
    initial begin
        logic          gc, gd, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [2:0]    e_f3;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_c_ready", c_ready, 1'b0);
                chk("rst_d_ready", d_ready, 1'b0);
                chk("rst_MemRead", MemRead, 1'b0);
                chk("rst_MemWrite", MemWrite, 1'b0);
                chk("rst_c_rvalid", c_rvalid, 1'b0);
                chk("rst_d_rvalid", d_rvalid, 1'b0);
                chk("rst_c_rdata", c_rdata, 32'h0);
                chk("rst_d_rdata", d_rdata, 32'h0);
`ifdef DMEM_ARB_STATS_EN
                chk("rst_c_stall", c_stall_cnt, 32'h0);
                chk("rst_d_stall", d_stall_cnt, 32'h0);
`endif
                m_d_owns = 1'b0; m_burst = 0; m_starve = 0;
                m_c_rv = 1'b0; m_d_rv = 1'b0; m_c_rdata = '0; m_d_rdata = '0;
                m_c_stall = 0; m_d_stall = 0;
            end else begin
                gc = 1'b0;
                gd = 1'b0;
                if (!m_d_owns) begin
                    if (c_valid && !(d_valid && m_starve >= STARVE_LIMIT)) gc = 1'b1;
                    else if (d_valid) gd = 1'b1;
                end else begin
                    if (d_valid && (m_burst < BURST_MAX || !c_valid)) gd = 1'b1;
                    else if (c_valid) gc = 1'b1;
                end
                e_we   = gd ? d_we     : c_we;
                e_addr = gd ? d_addr   : c_addr;
                e_wd   = gd ? d_wdata  : c_wdata;
                e_f3   = gd ? d_funct3 : c_funct3;

                chk("c_ready", c_ready, gc);
                chk("d_ready", d_ready, gd);
                chk("MemRead", MemRead, (gc | gd) & ~e_we);
                chk("MemWrite", MemWrite, (gc | gd) & e_we);
                chk("a", a, e_addr);
                chk("wd", wd, e_wd);
                chk("Funct3", Funct3, e_f3);
                chk("c_rvalid", c_rvalid, m_c_rv);
                chk("c_rdata", c_rdata, m_c_rdata);
                chk("d_rvalid", d_rvalid, m_d_rv);
                chk("d_rdata", d_rdata, m_d_rdata);
`ifdef DMEM_ARB_STATS_EN
                chk("c_stall_cnt", c_stall_cnt, m_c_stall);
                chk("d_stall_cnt", d_stall_cnt, m_d_stall);
`endif
                if (c_rvalid) begin c_rv_cnt++; c_last = c_rdata; end
                if (d_rvalid) begin d_rv_cnt++; d_last = d_rdata; end
                if (c_valid && c_ready) c_acc++;
                if (d_valid && d_ready) d_acc++;

                if (gc || gd) begin
                    glog = {glog, gc ? "C" : "D"};
                    $display("xfer %s %s a=0x%03h wd=0x%08h f3=%0d", gc ? "C" : "D",
                             e_we ? "store" : "load ", e_addr, e_wd, e_f3);
                end

                if (c_valid && !gc && m_c_stall < 65535) m_c_stall++;
                if (d_valid && !gd && m_d_stall < 65535) m_d_stall++;

                m_c_rv = 1'b0;
                m_d_rv = 1'b0;
                if (gc) begin
                    if (c_we) mm[c_addr] = c_wdata;
                    else begin m_c_rv = 1'b1; m_c_rdata = mm[c_addr]; end
                end
                if (gd) begin
                    if (d_we) mm[d_addr] = d_wdata;
                    else begin m_d_rv = 1'b1; m_d_rdata = mm[d_addr]; end
                end

                if (gd) begin
                    m_burst  = !m_d_owns ? 1 : (m_burst < BURST_MAX ? m_burst + 1 : m_burst);
                    m_d_owns = 1'b1;
                    m_starve = 0;
                end else begin
                    if (m_d_owns) begin m_d_owns = 1'b0; m_burst = 0; end
                    if (d_valid && m_starve < STARVE_LIMIT) m_starve++;
                end
            end
        end
    end

    task automatic push_c(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [2:0] f3);
        c_buf[c_tail] = '{we: we, addr: addr, wdata: wdata, f3: f3};
        c_tail++;
    endtask

    task automatic push_d(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [2:0] f3);
        d_buf[d_tail] = '{we: we, addr: addr, wdata: wdata, f3: f3};
        d_tail++;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] val);
        mem[addr] = val;
        mm[addr]  = val;
    endtask

    task automatic wait_idle(input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk); #1;
            if (c_pop == c_tail && d_pop == d_tail && !c_valid && !d_valid) done = 1'b1;
        end
        chk("idle_within_budget", {31'b0, done}, 32'h1);
        repeat (2) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_rv0, d_rv0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            mm[i]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;

        // Single C load
        preload(9'h010, 32'hDEADBEEF);
        c_rv0 = c_rv_cnt; d_rv0 = d_rv_cnt;
        push_c(1'b0, 9'h010, 32'h0, 3'b010);
        wait_idle(20);
        chk("t1_c_rvalid_pulses", c_rv_cnt - c_rv0, 32'd1);
        chk("t1_c_rdata", c_last, 32'hDEADBEEF);
        chk("t1_d_rvalid_pulses", d_rv_cnt - d_rv0, 32'd0);

        // C streaming, one D request waiting: D wins after 8 C grants
        glog = "";
        for (int i = 0; i < 10; i++) push_c(1'b0, 9'(9'h040 + i), 32'h0, 3'b010);
        push_d(1'b0, 9'h050, 32'h0, 3'b010);
        wait_idle(40);
        chk_str("t2_grant_order", glog, "CCCCCCCCDCC");
        chk("t2_starve_cleared", m_starve, 32'd0);

        // D burst of 6 stores, C arrives after the first D grant
        glog = "";
        for (int i = 0; i < 6; i++) push_d(1'b1, 9'(9'h100 + i), 32'hA5A50000 + i, 3'b010);
        @(negedge clk); #1;
        push_c(1'b1, 9'h1F0, 32'h0C0C0C0C, 3'b010);
        wait_idle(40);
        chk_str("t3_grant_order", glog, "DDDDCDD");
        for (int i = 0; i < 6; i++) chk("t3_mem", mem[9'h100 + i], 32'hA5A50000 + i);
        chk("t3_c_store", mem[9'h1F0], 32'h0C0C0C0C);

        // D byte store, then C unsigned byte load of the same word
        push_d(1'b1, 9'h020, 32'h000000AB, 3'b000);
        wait_idle(20);
        push_c(1'b0, 9'h020, 32'h0, 3'b100);
        wait_idle(20);
        chk("t4_c_rdata", c_last, 32'h000000AB);

        // Same-address C load vs D store: C wins and sees the old value
        preload(9'h030, 32'h11111111);
        glog = "";
        push_c(1'b0, 9'h030, 32'h0, 3'b010);
        push_d(1'b1, 9'h030, 32'h22222222, 3'b010);
        wait_idle(20);
        chk_str("t5_grant_order", glog, "CD");
        chk("t5_c_old_value", c_last, 32'h11111111);
        push_c(1'b0, 9'h030, 32'h0, 3'b010);
        wait_idle(20);
        chk("t5_c_new_value", c_last, 32'h22222222);

        // Reset the cycle after a C load grant
        c_rv0 = c_rv_cnt;
        push_c(1'b0, 9'h010, 32'h0, 3'b010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        push_c(1'b0, 9'h044, 32'h0, 3'b010);
        push_d(1'b0, 9'h045, 32'h0, 3'b010);
        repeat (3) @(negedge clk);
        glog = "";
        @(posedge clk); #2;
        rst_n = 1'b1;
        wait_idle(20);
        chk_str("t6_after_reset_order", glog, "CD");
        chk("t6_c_rvalid_pulses", c_rv_cnt - c_rv0, 32'd1);

        // D blocked 5 cycles behind C
        do_reset();
        glog = "";
        for (int i = 0; i < 5; i++) push_c(1'b1, 9'(9'h080 + i), 32'h5000 + i, 3'b010);
        push_d(1'b1, 9'h090, 32'h9999, 3'b010);
        wait_idle(30);
        chk_str("t7_grant_order", glog, "CCCCCD");
`ifdef DMEM_ARB_STATS_EN
        chk("t7_d_stall_cnt", d_stall_cnt, 32'd5);
        chk("t7_c_stall_cnt", c_stall_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
